// File: rtl/prg_scan_gen.sv
// Raster scan generator: walks (x, y, sample) in s-fastest / x-ascending / y-descending
// order into a first-word-fall-through queue drained under downstream stall.
module prg_scan_gen #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int SPP   = 1,
    parameter int DEPTH = 16,
    parameter int XW    = (H_RES > 1) ? $clog2(H_RES) : 1,
    parameter int YW    = (V_RES > 1) ? $clog2(V_RES) : 1,
    parameter int SW    = (SPP > 1) ? $clog2(SPP) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       out_stall,
    output logic                       out_valid,
    output logic [XW-1:0]              out_x,
    output logic [YW-1:0]              out_y,
    output logic [SW-1:0]              out_s,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 1 + SW + YW + XW;
    localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_TOP = YW'(V_RES - 1);
    localparam logic [SW-1:0] S_MAX = SW'(SPP - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DONE} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [SW-1:0]   s_q, s_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   head;
    logic            push, pop, item_last;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        s_d       = s_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        pop       = (count_q != '0) && !out_stall;
        item_last = (x_q == X_MAX) && (y_q == '0) && (s_q == S_MAX);
        // A full queue still accepts a push when the head leaves in the same cycle.
        push      = (state_q == ST_SCAN) && !abort && ((count_q < CW'(DEPTH)) || pop);

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = '0;
                    y_d     = Y_TOP;
                    s_d     = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (push) begin
                    if (s_q == S_MAX) begin
                        s_d = '0;
                        if (x_q == X_MAX) begin
                            x_d = '0;
                            y_d = y_q - 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                    if (item_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Look at next occupancy so done lands the cycle after the last pop.
                if (count_d == '0) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d  = ST_IDLE;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= Y_TOP;
            s_q      <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            s_q      <= s_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage carries no reset; outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {item_last, s_q, y_q, x_q};
    end

    assign head      = mem[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign out_x     = out_valid ? head[XW-1:0]       : '0;
    assign out_y     = out_valid ? head[XW +: YW]      : '0;
    assign out_s     = out_valid ? head[XW+YW +: SW]   : '0;
    assign out_last  = out_valid ? head[EW-1]          : 1'b0;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign q_count   = count_q;

endmodule
